// File: rtl/lsu_ctrl_if.sv
// Request handshake bundle between the EX stage and the load/store unit.
// The EX stage holds the master modport and the LSU holds the slave modport.
`timescale 1ns/1ps
interface lsu_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic              req_byte;
    logic [31:0]       req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [4:0]        req_rd;

    modport master (
        output req_valid, req_we, req_byte, req_addr, req_wdata, req_rd,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_we, req_byte, req_addr, req_wdata, req_rd,
        output req_ready
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store control between the ALU result and a 2**ADDR_W-word data memory; byte stores use read-modify-write.
// Optional build macro LSU_ALIGN_CHECK_EN: reject misaligned word accesses and out-of-range addresses with a fault pulse.
`timescale 1ns/1ps
module lsu_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    lsu_ctrl_if.slave         req,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [1:0]        dm_lb,
    output logic              dm_wb,
    output logic [DATA_W-1:0] dm_wdata,
    output logic              dm_memwr,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic [4:0]        wb_rd,
    output logic              fault
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        STORE  = 3'd2,
        RMW_RD = 3'd3,
        RMW_WR = 3'd4
    } state_t;

    state_t              state_q,    state_d;
    logic [ADDR_W+1:0]   addr_q,     addr_d;
    logic [DATA_W-1:0]   wdata_q,    wdata_d;
    logic [4:0]          rd_q,       rd_d;
    logic                byte_q,     byte_d;
    logic [DATA_W-1:0]   merge_q,    merge_d;
    logic                wb_valid_q, wb_valid_d;
    logic [DATA_W-1:0]   wb_data_q,  wb_data_d;
    logic [4:0]          wb_rd_q,    wb_rd_d;
    logic                fault_q,    fault_d;
    logic                req_bad;

    // Lane 0 is the most significant byte (big-endian lane numbering).
    function automatic logic [DATA_W-1:0] merge_byte(
        input logic [DATA_W-1:0] word,
        input logic [1:0]        lane,
        input logic [7:0]        bval
    );
        logic [DATA_W-1:0] res;
        int                lsb;
        res = word;
        lsb = DATA_W - 8 - 8 * int'(lane);
        res[lsb +: 8] = bval;
        return res;
    endfunction

`ifdef LSU_ALIGN_CHECK_EN
    assign req_bad = (!req.req_byte && (req.req_addr[1:0] != 2'b00)) ||
                     (req.req_addr[31:ADDR_W+2] != '0);
`else
    // Upper address bits simply wrap onto the memory when the check is disabled.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req.req_addr[31:ADDR_W+2];
    assign req_bad        = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        byte_d     = byte_q;
        merge_d    = merge_q;
        wb_valid_d = 1'b0;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        fault_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req.req_valid) begin
                    addr_d  = req.req_addr[ADDR_W+1:0];
                    wdata_d = req.req_wdata;
                    rd_d    = req.req_rd;
                    byte_d  = req.req_byte;
                    if (req_bad) begin
                        fault_d = 1'b1;
                    end else if (!req.req_we) begin
                        state_d = LOAD;
                    end else if (req.req_byte) begin
                        state_d = RMW_RD;
                    end else begin
                        state_d = STORE;
                    end
                end
            end
            LOAD: begin
                wb_valid_d = 1'b1;
                wb_data_d  = dm_rdata;
                wb_rd_d    = rd_q;
                state_d    = IDLE;
            end
            STORE: begin
                state_d = IDLE;
            end
            RMW_RD: begin
                merge_d = dm_rdata;
                state_d = RMW_WR;
            end
            RMW_WR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            byte_q     <= 1'b0;
            merge_q    <= '0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            byte_q     <= byte_d;
            merge_q    <= merge_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            fault_q    <= fault_d;
        end
    end

    // Memory port is decoded from the state so an async reset kills a pending write immediately.
    assign req.req_ready = (state_q == IDLE);
    assign dm_addr       = addr_q[ADDR_W+1:2];
    assign dm_lb         = addr_q[1:0];
    assign dm_wb         = (state_q == LOAD) && byte_q;
    assign dm_memwr      = (state_q == STORE) || (state_q == RMW_WR);

    always_comb begin
        dm_wdata = '0;
        if (state_q == STORE) begin
            dm_wdata = wdata_q;
        end else if (state_q == RMW_WR) begin
            dm_wdata = merge_byte(merge_q, addr_q[1:0], wdata_q[7:0]);
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_data  = wb_data_q;
    assign wb_rd    = wb_rd_q;
    assign fault    = fault_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: directed requests push expected write-back, memory-write and fault events;
// a negedge monitor pops and compares them, including the cycle on which each event must appear.
`timescale 1ns/1ps
module tb_lsu_ctrl;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    typedef struct {
        int          cyc;
        logic [31:0] a;
        logic [31:0] d;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ADDR_W-1:0] dm_addr;
    logic [1:0]        dm_lb;
    logic              dm_wb;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_memwr;
    logic [DATA_W-1:0] dm_rdata;
    logic              wb_valid;
    logic [DATA_W-1:0] wb_data;
    logic [4:0]        wb_rd;
    logic              fault;

    logic [31:0] mem [32];
    exp_t        wbq[$];
    exp_t        wrq[$];
    int          fq[$];
    int          checks = 0;
    int          errors = 0;
    int          ncyc = 0;

    lsu_ctrl_if #(.DATA_W(DATA_W)) rq ();

    lsu_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (rq),
        .dm_addr  (dm_addr),
        .dm_lb    (dm_lb),
        .dm_wb    (dm_wb),
        .dm_wdata (dm_wdata),
        .dm_memwr (dm_memwr),
        .dm_rdata (dm_rdata),
        .wb_valid (wb_valid),
        .wb_data  (wb_data),
        .wb_rd    (wb_rd),
        .fault    (fault)
    );

    always #5 clk = ~clk;

    // Data memory model: combinational read with optional sign-extended byte, write on negedge.
    always_comb begin
        logic [31:0] w;
        logic [7:0]  b;
        w = mem[dm_addr];
        b = w[31 - 8*int'(dm_lb) -: 8];
        dm_rdata = dm_wb ? {{24{b[7]}}, b} : w;
    end

    always @(negedge clk) begin
        if (dm_memwr) mem[dm_addr] <= dm_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every DUT event must match the head of its queue, on the predicted cycle.
    always @(negedge clk) begin
        exp_t e;
        ncyc = ncyc + 1;
        if (rst_n) begin
            while (wbq.size() > 0 && wbq[0].cyc < ncyc) begin
                e = wbq.pop_front(); checks++; errors++;
                $display("FAIL wb_missing: no wb_valid at cycle %0d for data 0x%08h", e.cyc, e.d);
            end
            while (wrq.size() > 0 && wrq[0].cyc < ncyc) begin
                e = wrq.pop_front(); checks++; errors++;
                $display("FAIL wr_missing: no dm_memwr at cycle %0d for data 0x%08h", e.cyc, e.d);
            end
            while (fq.size() > 0 && fq[0] < ncyc) begin
                void'(fq.pop_front()); checks++; errors++;
                $display("FAIL fault_missing: expected fault pulse not seen");
            end
            if (wb_valid) begin
                checks++;
                if (wbq.size() == 0) begin
                    errors++;
                    $display("FAIL wb_unexpected: wb_valid=1 data 0x%08h, expected no write-back", wb_data);
                end else begin
                    e = wbq.pop_front();
                    if (e.cyc != ncyc || wb_rd != e.a[4:0] || wb_data !== e.d) begin
                        errors++;
                        $display("FAIL wb: cyc %0d rd %0d data 0x%08h, expected cyc %0d rd %0d data 0x%08h",
                                 ncyc, wb_rd, wb_data, e.cyc, e.a[4:0], e.d);
                    end
                end
            end
            if (dm_memwr) begin
                checks++;
                if (wrq.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected: dm_memwr=1 addr %0d data 0x%08h, expected none", dm_addr, dm_wdata);
                end else begin
                    e = wrq.pop_front();
                    if (e.cyc != ncyc || dm_addr != e.a[4:0] || dm_wdata !== e.d) begin
                        errors++;
                        $display("FAIL wr: cyc %0d addr %0d data 0x%08h, expected cyc %0d addr %0d data 0x%08h",
                                 ncyc, dm_addr, dm_wdata, e.cyc, e.a[4:0], e.d);
                    end
                end
            end
            if (fault) begin
                checks++;
                if (fq.size() == 0 || fq[0] != ncyc) begin
                    errors++;
                    $display("FAIL fault_unexpected: fault=1 at cycle %0d, expected 0", ncyc);
                end else begin
                    void'(fq.pop_front());
                end
            end
            if (wb_valid && fault) begin
                checks++; errors++;
                $display("FAIL wb_fault_overlap: wb_valid=1 fault=1, expected not both");
            end
        end else if (dm_memwr) begin
            checks++; errors++;
            $display("FAIL wr_in_reset: dm_memwr=1 expected 0");
        end
    end

    // Issue one request; exp is the load result or, for byte stores, the merged word written back.
    task automatic issue(input string name, input bit we, input bit bt, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd, input logic [31:0] exp,
                         input bit exp_fault);
        int   n;
        int   k;
        exp_t e;
        rq.req_valid = 1'b1;
        rq.req_we    = we;
        rq.req_byte  = bt;
        rq.req_addr  = addr;
        rq.req_wdata = wdata;
        rq.req_rd    = rd;
        n = 0;
        do begin
            @(negedge clk); #1; n++;
        end while (!rq.req_ready && n < 50);
        if (!rq.req_ready) begin
            checks++; errors++;
            $display("FAIL %s_timeout: req_ready=0 after %0d cycles, expected 1", name, n);
            rq.req_valid = 1'b0;
            return;
        end
        k = ncyc;
        if (exp_fault) begin
            fq.push_back(k + 1);
        end else if (!we) begin
            e.cyc = k + 2; e.a = {27'd0, rd}; e.d = exp; wbq.push_back(e);
        end else if (!bt) begin
            e.cyc = k + 1; e.a = {27'd0, addr[6:2]}; e.d = wdata; wrq.push_back(e);
        end else begin
            e.cyc = k + 2; e.a = {27'd0, addr[6:2]}; e.d = exp; wrq.push_back(e);
        end
        @(posedge clk); #1;
        rq.req_valid = 1'b0;
        chk({name, "_ready"}, {31'd0, rq.req_ready}, {31'd0, exp_fault});
        if (!exp_fault) chk({name, "_dm_addr"}, {27'd0, dm_addr}, {27'd0, addr[6:2]});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'd0;
        mem[0] = 32'h89AB_CDEF;
        mem[5] = 32'h0000_0014;
        rq.req_valid = 1'b0;
        rq.req_we    = 1'b0;
        rq.req_byte  = 1'b0;
        rq.req_addr  = 32'd0;
        rq.req_wdata = 32'd0;
        rq.req_rd    = 5'd0;

        #3;
        chk("rst_ready",    {31'd0, rq.req_ready}, 32'd1);
        chk("rst_memwr",    {31'd0, dm_memwr}, 32'd0);
        chk("rst_dm_wb",    {31'd0, dm_wb}, 32'd0);
        chk("rst_dm_addr",  {27'd0, dm_addr}, 32'd0);
        chk("rst_dm_lb",    {30'd0, dm_lb}, 32'd0);
        chk("rst_dm_wdata", dm_wdata, 32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_wb_data",  wb_data, 32'd0);
        chk("rst_wb_rd",    {27'd0, wb_rd}, 32'd0);
        chk("rst_fault",    {31'd0, fault}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue("lw14",   1'b0, 1'b0, 32'h14, 32'h0,           5'd3, 32'h0000_0014, 1'b0);
        issue("sw20",   1'b1, 1'b0, 32'h20, 32'hDEAD_BEEF,   5'd0, 32'h0,         1'b0);
        issue("lw20",   1'b0, 1'b0, 32'h20, 32'h0,           5'd4, 32'hDEAD_BEEF, 1'b0);
        issue("sw20b",  1'b1, 1'b0, 32'h20, 32'h1122_3344,   5'd0, 32'h0,         1'b0);
        issue("sb21",   1'b1, 1'b1, 32'h21, 32'h0000_0080,   5'd0, 32'h1180_3344, 1'b0);
        issue("lb21",   1'b0, 1'b1, 32'h21, 32'h0,           5'd5, 32'hFFFF_FF80, 1'b0);
        chk("mem8_after_sb", mem[8], 32'h1180_3344);
        issue("lb23",   1'b0, 1'b1, 32'h23, 32'h0,           5'd7, 32'h0000_0044, 1'b0);
        issue("sb24",   1'b1, 1'b1, 32'h24, 32'hFFFF_FF7F,   5'd0, 32'h7F00_0000, 1'b0);
        issue("lw24",   1'b0, 1'b0, 32'h24, 32'h0,           5'd8, 32'h7F00_0000, 1'b0);

        issue("b2b_lw", 1'b0, 1'b0, 32'h14, 32'h0,           5'd1, 32'h0000_0014, 1'b0);
        issue("b2b_sw", 1'b1, 1'b0, 32'h28, 32'hCAFE_F00D,   5'd0, 32'h0,         1'b0);
        issue("b2b_lw2",1'b0, 1'b0, 32'h28, 32'h0,           5'd2, 32'hCAFE_F00D, 1'b0);
        issue("b2b_lb", 1'b0, 1'b1, 32'h2A, 32'h0,           5'd9, 32'hFFFF_FFF0, 1'b0);

        issue("lb03",   1'b0, 1'b1, 32'h03, 32'h0,           5'd10, 32'hFFFF_FFEF, 1'b0);
`ifdef LSU_ALIGN_CHECK_EN
        issue("lw03",   1'b0, 1'b0, 32'h03, 32'h0,           5'd11, 32'h0, 1'b1);
        issue("lw94",   1'b0, 1'b0, 32'h94, 32'h0,           5'd12, 32'h0, 1'b1);
        issue("sw22",   1'b1, 1'b0, 32'h22, 32'h0BAD_0BAD,   5'd0,  32'h0, 1'b1);
        repeat (2) @(negedge clk);
        chk("mem8_after_fault", mem[8], 32'h1180_3344);
`else
        issue("lw03",   1'b0, 1'b0, 32'h03, 32'h0,           5'd11, 32'h89AB_CDEF, 1'b0);
        issue("lw94",   1'b0, 1'b0, 32'h94, 32'h0,           5'd12, 32'h0000_0014, 1'b0);
`endif

        // Byte store abandoned by reset while reading the old word.
        rq.req_valid = 1'b1;
        rq.req_we    = 1'b1;
        rq.req_byte  = 1'b1;
        rq.req_addr  = 32'h20;
        rq.req_wdata = 32'h0000_0055;
        begin
            int n;
            n = 0;
            do begin
                @(negedge clk); #1; n++;
            end while (!rq.req_ready && n < 50);
            chk("rmw_rst_ready_before", {31'd0, rq.req_ready}, 32'd1);
        end
        @(posedge clk); #1;
        rq.req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rmw_rst_memwr", {31'd0, dm_memwr}, 32'd0);
        chk("rmw_rst_ready", {31'd0, rq.req_ready}, 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("mem8_after_rst", mem[8], 32'h1180_3344);
        @(posedge clk); #1;
        issue("lw20_post", 1'b0, 1'b0, 32'h20, 32'h0, 5'd13, 32'h1180_3344, 1'b0);

        repeat (5) @(negedge clk);
        #1;
        chk("wbq_drained", wbq.size(), 32'd0);
        chk("wrq_drained", wrq.size(), 32'd0);
        chk("fq_drained",  fq.size(),  32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
